button_cmd_gen: RTL and testbench
=================================

BUTTON_CMD_GEN -- requirements
Module: button_cmd_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples required to accept a level change (legal range 1..65535).
REQ-002 Parameter LONG_PRESS_CYCLES, default 1000000, debounced hold length that triggers reset (used only under REQ-021).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_ss_raw  input  1  raw start/stop pushbutton, asynchronous, active-high.
REQ-006 btn_rst_raw  input  1  raw reset pushbutton, asynchronous, active-high.
REQ-007 status  input  2  stopwatch controller state: 00 idle, 01 running, 10 paused, 11 invalid.
REQ-008 start  output  1  one-cycle command pulse to controller.
REQ-009 stop  output  1  one-cycle command pulse to controller.
REQ-010 reset  output  1  one-cycle command pulse to controller.

Function
REQ-011 Each raw button SHALL pass through a dedicated 2-flop synchronizer before any other use.
REQ-012 Per button, a debounced level SHALL toggle only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears the count.
REQ-013 A debounced 0->1 transition is a press; 1->0 is a release; releases generate no command.
REQ-014 A start/stop press SHALL generate stop if status==01, start if status==00 or 10, and nothing if status==11; status is sampled in the cycle the press is detected.
REQ-015 A reset-button press SHALL generate reset regardless of status.
REQ-016 All outputs SHALL be registered; each pulse high for exactly one cycle per press.
REQ-017 Latency: pulse asserts DEBOUNCE_CYCLES+3 cycles after the first rising edge sampling the new stable raw level.
REQ-018 Simultaneous start/stop and reset presses in one cycle: reset only; start/stop suppressed.
REQ-019 At most one of start, stop, reset SHALL be high in any cycle.
REQ-020 Bounce shorter than DEBOUNCE_CYCLES, of any pattern, SHALL produce no pulse and no debounced-level change.

Reset
REQ-021 While rst is high: start, stop, reset = 0; synchronizers, debounced levels, all counters = 0.
REQ-022 Reset mid-debounce or mid-hold SHALL discard the partial count; a button held through rst deassertion SHALL be treated as a new press after REQ-017 latency.

Configuration
REQ-023 Macro LONG_PRESS_RESET_EN defined: a counter runs while debounced start/stop is high, saturating; on reaching LONG_PRESS_CYCLES it SHALL emit one reset pulse (in addition to the earlier start/stop), with no further pulse until release and re-press; release clears the counter.
REQ-024 Macro LONG_PRESS_RESET_EN undefined: no hold counter exists; LONG_PRESS_CYCLES is unused; holding start/stop only yields the REQ-014 pulse.
REQ-025 Hold counter width SHALL be sized from LONG_PRESS_CYCLES; no wrap permitted.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-026 status=00, btn_ss_raw 0->1 held -> start high exactly 1 cycle, 7 cycles after first sampling edge; stop, reset stay 0.
REQ-027 status=01, clean ss press -> single stop pulse; status=10 press -> single start; status=11 press -> no pulse.
REQ-028 btn_ss_raw toggling every 2 cycles for 30 cycles then settling low -> zero pulses on all outputs.
REQ-029 both raw buttons rise same edge, status=00 -> reset pulse only, start 0 throughout.
REQ-030 rst asserted 2 cycles into a 4-cycle debounce, ss held -> no pulse during rst; start pulse 7 cycles after rst deasserts.
REQ-031 LONG_PRESS_RESET_EN defined, ss held 40 cycles, status=01 -> stop pulse then exactly one reset pulse 20 cycles after debounced press; undefined -> stop only.

Source files
------------

// File: rtl/button_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : button_cmd_gen
// Description : Debounces start/stop and reset pushbuttons and issues
//               one-cycle start/stop/reset commands to a stopwatch controller.
//               Optional long-press reset enabled by macro LONG_PRESS_RESET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module button_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter int unsigned LONG_PRESS_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss_raw,
    input  logic       btn_rst_raw,
    input  logic [1:0] status,
    output logic       start,
    output logic       stop,
    output logic       reset
);

    localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]      ST_IDLE  = 2'b00;
    localparam logic [1:0]      ST_RUN   = 2'b01;
    localparam logic [1:0]      ST_PAUSE = 2'b10;
    localparam int              BTN_SS  = 0;
    localparam int              BTN_RST = 1;

    logic [1:0] btn_raw;
    logic [1:0] btn_deb;
    logic [1:0] press;
    logic       long_hit;

    assign btn_raw = {btn_rst_raw, btn_ss_raw};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic            sync1_q, sync1_d;
        logic            sync2_q, sync2_d;
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            deb_q, deb_d;
        logic            deb_prev_q, deb_prev_d;
        logic            press_q, press_d;

        always_comb begin
            sync1_d    = btn_raw[gi];
            sync2_d    = sync1_q;
            cnt_d      = '0;
            deb_d      = deb_q;
            // Any agreeing sample leaves cnt_d at zero, restarting the run.
            if (sync2_q != deb_q) begin
                if (cnt_q == DB_LAST) begin
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            deb_prev_d = deb_q;
            press_d    = deb_q & ~deb_prev_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                cnt_q      <= '0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                press_q    <= 1'b0;
            end else begin
                sync1_q    <= sync1_d;
                sync2_q    <= sync2_d;
                cnt_q      <= cnt_d;
                deb_q      <= deb_d;
                deb_prev_q <= deb_prev_d;
                press_q    <= press_d;
            end
        end

        assign btn_deb[gi] = deb_q;
        assign press[gi]   = press_q;
    end

`ifdef LONG_PRESS_RESET_EN
    localparam int unsigned     LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    logic [LP_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            unused_deb;

    // Saturating at LP_MAX guarantees a single reset per continuous hold.
    always_comb begin
        hold_cnt_d = '0;
        if (btn_deb[BTN_SS]) begin
            hold_cnt_d = (hold_cnt_q == LP_MAX) ? hold_cnt_q : hold_cnt_q + LP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign long_hit   = btn_deb[BTN_SS] && (hold_cnt_q == LP_LAST);
    assign unused_deb = btn_deb[BTN_RST];
`else
    logic unused_cfg;

    assign long_hit   = 1'b0;
    assign unused_cfg = ^{btn_deb, LONG_PRESS_CYCLES == 0};
`endif

    logic start_q, start_d;
    logic stop_q,  stop_d;
    logic reset_q, reset_d;

    // Reset has priority; a coincident start/stop press is dropped.
    always_comb begin
        reset_d = press[BTN_RST] | long_hit;
        start_d = 1'b0;
        stop_d  = 1'b0;
        if (!reset_d && press[BTN_SS]) begin
            start_d = (status == ST_IDLE) || (status == ST_PAUSE);
            stop_d  = (status == ST_RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            reset_q <= 1'b0;
        end else begin
            start_q <= start_d;
            stop_q  <= stop_d;
            reset_q <= reset_d;
        end
    end

    assign start = start_q;
    assign stop  = stop_q;
    assign reset = reset_q;

endmodule
`default_nettype wire

// File: tb/tb_button_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_cmd_gen
// Description : Scoreboard bench for button_cmd_gen (DEBOUNCE=4, LONG=20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_cmd_gen;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss_raw;
    logic       btn_rst_raw;
    logic [1:0] status;
    logic       start;
    logic       stop;
    logic       reset;

    button_cmd_gen #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_ss_raw  (btn_ss_raw),
        .btn_rst_raw (btn_rst_raw),
        .status      (status),
        .start       (start),
        .stop        (stop),
        .reset       (reset)
    );

    always #5 clk = ~clk;

    // cmd encoding: {start, stop, reset}
    typedef struct {
        int         cyc;
        logic [2:0] cmd;
    } exp_t;

    exp_t exp_q[$];
    int   ss_due_q[$];
    int   rb_due_q[$];
    int   long_due;
    int   cyc;
    int   run[2];
    logic lvl[2];
    int   n_cmp;
    int   n_bad;

    // Reference model: a level is accepted after DEB consecutive raw samples
    // disagree with it; a press yields a command DEB+3 edges after the first
    // sample of the run, i.e. 4 edges after the run completes.
    initial begin
        logic [1:0] smp;
        logic       ss_hit, rb_hit, lp_hit;
        exp_t       e;
        cyc      = 0;
        long_due = -1;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                ss_due_q.delete();
                rb_due_q.delete();
                long_due = -1;
                for (int b = 0; b < 2; b++) begin
                    run[b] = 0;
                    lvl[b] = 1'b0;
                end
            end else begin
                ss_hit = (ss_due_q.size() != 0) && (ss_due_q[0] == cyc);
                if (ss_hit) void'(ss_due_q.pop_front());
                rb_hit = (rb_due_q.size() != 0) && (rb_due_q[0] == cyc);
                if (rb_hit) void'(rb_due_q.pop_front());
                lp_hit = (long_due == cyc);
                if (lp_hit) long_due = -1;
                e.cyc = cyc;
                if (rb_hit || lp_hit) begin
                    e.cmd = 3'b001;
                    exp_q.push_back(e);
                end else if (ss_hit && status != 2'b11) begin
                    e.cmd = (status == 2'b01) ? 3'b010 : 3'b100;
                    exp_q.push_back(e);
                end
                smp = {btn_rst_raw, btn_ss_raw};
                for (int b = 0; b < 2; b++) begin
                    if (smp[b] != lvl[b]) begin
                        run[b]++;
                        if (run[b] == DEB) begin
                            lvl[b] = smp[b];
                            run[b] = 0;
                            if (smp[b]) begin
                                if (b == 0) ss_due_q.push_back(cyc + 4);
                                else        rb_due_q.push_back(cyc + 4);
`ifdef LONG_PRESS_RESET_EN
                                // debounced level rises 2 edges after the run completes
                                if (b == 0) long_due = cyc + 2 + LONG;
`endif
                            end else if (b == 0 && long_due > cyc + 2) begin
                                long_due = -1;
                            end
                        end
                    end else begin
                        run[b] = 0;
                    end
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard.
    initial begin
        logic [2:0] got;
        exp_t       e;
        n_cmp = 0;
        n_bad = 0;
        forever begin
            @(negedge clk);
            got = {start, stop, reset};
            if (rst) begin
                n_cmp++;
                if (got != 3'b000) begin
                    n_bad++;
                    $display("FAIL reset_state cyc=%0d got=%b want=000", cyc, got);
                end
                while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
            end else begin
                while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missed_pulse cyc=%0d got=none want=%b@%0d", cyc, e.cmd, e.cyc);
                end
                if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (got != e.cmd) begin
                        n_bad++;
                        $display("FAIL cmd cyc=%0d got=%b want=%b", cyc, got, e.cmd);
                    end
                end else if (got != 3'b000) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_pulse cyc=%0d got=%b want=000", cyc, got);
                end
            end
        end
    end

    task automatic drive(input logic ss, input logic rb, input logic [1:0] st, input int n);
        btn_ss_raw  = ss;
        btn_rst_raw = rb;
        status      = st;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic       r_ss, r_rb;
        logic [1:0] r_st;
        rst         = 1'b1;
        btn_ss_raw  = 1'b0;
        btn_rst_raw = 1'b0;
        status      = 2'b00;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(0, 0, 2'b00, 5);

        // clean presses under each status
        drive(1, 0, 2'b00, 12); drive(0, 0, 2'b00, 12);
        drive(1, 0, 2'b01, 12); drive(0, 0, 2'b01, 12);
        drive(1, 0, 2'b10, 12); drive(0, 0, 2'b10, 12);
        drive(1, 0, 2'b11, 12); drive(0, 0, 2'b11, 12);

        // bounce every 2 cycles, then settle low
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 2'b00, 2);
            drive(0, 0, 2'b00, 2);
        end
        drive(0, 0, 2'b00, 12);

        // simultaneous presses
        drive(1, 1, 2'b00, 12); drive(0, 0, 2'b00, 12);

        // reset two cycles into a debounce with the button held
        drive(1, 0, 2'b00, 2);
        rst = 1'b1;
        drive(1, 0, 2'b00, 3);
        rst = 1'b0;
        drive(1, 0, 2'b00, 15); drive(0, 0, 2'b00, 12);

        // long hold while running
        drive(1, 0, 2'b01, 40); drive(0, 0, 2'b01, 12);

        // randomized segments with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            r_ss = 1'($urandom_range(0, 1));
            r_rb = ($urandom_range(0, 3) == 0);
            r_st = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) begin
                rst = 1'b1;
                drive(r_ss, r_rb, r_st, $urandom_range(1, 3));
                rst = 1'b0;
            end
            drive(r_ss, r_rb, r_st, $urandom_range(1, 14));
        end

        drive(0, 0, 2'b00, 30);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d_pending want=0_pending", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
